// File: rtl/rtc_alarm_clock.sv
// Real-time clock with a millisecond prescaler, h:m:s.ms cascade, run/pause control
// and one hh:mm alarm, driven by a one-command-per-cycle control bus.
module rtc_alarm_clock #(
    parameter int CLKS_PER_MS   = 1,
    parameter int HOURS_PER_DAY = 24
) (
    input  logic       clk_i,
    input  logic       arst_n_i,
    input  logic       cmd_valid_i,
    input  logic [2:0] cmd_type_i,
    input  logic [9:0] cmd_data_i,
    output logic [4:0] hours_o,
    output logic [5:0] minutes_o,
    output logic [5:0] seconds_o,
    output logic [9:0] milliseconds_o,
    output logic       running_o,
    output logic       alarm_o,
    output logic       alarm_pending_o
);

    localparam int            PW         = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_MS - 1);
    localparam logic [4:0]    HOUR_LAST  = 5'(HOURS_PER_DAY - 1);
    localparam logic [4:0]    HOUR_MOD   = 5'(HOURS_PER_DAY);

    typedef enum logic [2:0] {
        CMD_CONTROL         = 3'b000,
        CMD_SET_ALARM_MIN   = 3'b001,
        CMD_RESET_TIME      = 3'b010,
        CMD_SET_MS          = 3'b011,
        CMD_SET_ALARM_HOURS = 3'b100,
        CMD_SET_SECONDS     = 3'b101,
        CMD_SET_MINUTES     = 3'b110,
        CMD_SET_HOURS       = 3'b111
    } cmd_e;

    cmd_e          cmd;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_nx;
    logic [4:0]    alarm_h_q;
    logic [5:0]    alarm_m_q;
    logic          alarm_en_q;

    logic          time_cmd;
    logic          ctrl_cmd;
    logic          tick;
    logic          alarm_en_eff;
    logic          fire;
    logic          ms_wrap, s_wrap, m_wrap, h_wrap;
    logic [4:0]    h_nx;
    logic [5:0]    m_nx;
    logic [5:0]    s_nx;
    logic [9:0]    ms_nx;
    logic [4:0]    set_h;
    logic [5:0]    set_m;
    logic [9:0]    set_ms;

    assign cmd = cmd_e'(cmd_type_i);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        time_cmd     = 1'b0;
        ctrl_cmd     = 1'b0;
        if (cmd_valid_i) begin
            time_cmd = (cmd == CMD_SET_HOURS)   || (cmd == CMD_SET_MINUTES) ||
                       (cmd == CMD_SET_SECONDS) || (cmd == CMD_SET_MS)      ||
                       (cmd == CMD_RESET_TIME);
            ctrl_cmd = (cmd == CMD_CONTROL);
        end

        // A time write restarts the millisecond, so a coinciding tick is discarded.
        tick = running_o && (presc_q == PRESC_LAST) && !time_cmd;

        presc_nx = presc_q;
        if (time_cmd) begin
            presc_nx = '0;
        end else if (running_o) begin
            presc_nx = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        end

        ms_wrap = (milliseconds_o == 10'd999);
        s_wrap  = (seconds_o == 6'd59);
        m_wrap  = (minutes_o == 6'd59);
        h_wrap  = (hours_o == HOUR_LAST);

        ms_nx = ms_wrap ? 10'd0 : milliseconds_o + 10'd1;
        s_nx  = seconds_o;
        m_nx  = minutes_o;
        h_nx  = hours_o;
        if (ms_wrap) begin
            s_nx = s_wrap ? 6'd0 : seconds_o + 6'd1;
            if (s_wrap) begin
                m_nx = m_wrap ? 6'd0 : minutes_o + 6'd1;
                if (m_wrap) begin
                    h_nx = h_wrap ? 5'd0 : hours_o + 5'd1;
                end
            end
        end

        // A CONTROL command that clears the enable in the firing cycle wins over the fire.
        alarm_en_eff = alarm_en_q && !(ctrl_cmd && !cmd_data_i[1]);
        fire = tick && alarm_en_eff && (ms_nx == 10'd0) && (s_nx == 6'd0) &&
               (m_nx == alarm_m_q) && (h_nx == alarm_h_q);

        set_h  = cmd_data_i[9:5] % HOUR_MOD;
        set_m  = cmd_data_i[9:4] % 6'd60;
        set_ms = cmd_data_i % 10'd1000;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            presc_q         <= '0;
            hours_o         <= '0;
            minutes_o       <= '0;
            seconds_o       <= '0;
            milliseconds_o  <= '0;
            running_o       <= 1'b1;
            alarm_h_q       <= '0;
            alarm_m_q       <= '0;
            alarm_en_q      <= 1'b0;
            alarm_o         <= 1'b0;
            alarm_pending_o <= 1'b0;
        end else begin
            presc_q <= presc_nx;
            alarm_o <= fire;

            if (fire) begin
                alarm_pending_o <= 1'b1;
            end else if (ctrl_cmd && cmd_data_i[2]) begin
                alarm_pending_o <= 1'b0;
            end

            if (tick) begin
                hours_o        <= h_nx;
                minutes_o      <= m_nx;
                seconds_o      <= s_nx;
                milliseconds_o <= ms_nx;
            end

            if (cmd_valid_i) begin
                case (cmd)
                    CMD_SET_HOURS:       hours_o        <= set_h;
                    CMD_SET_MINUTES:     minutes_o      <= set_m;
                    CMD_SET_SECONDS:     seconds_o      <= set_m;
                    CMD_SET_MS:          milliseconds_o <= set_ms;
                    CMD_RESET_TIME: begin
                        hours_o        <= '0;
                        minutes_o      <= '0;
                        seconds_o      <= '0;
                        milliseconds_o <= '0;
                    end
                    CMD_SET_ALARM_HOURS: alarm_h_q      <= set_h;
                    CMD_SET_ALARM_MIN:   alarm_m_q      <= set_m;
                    CMD_CONTROL: begin
                        running_o  <= cmd_data_i[0];
                        alarm_en_q <= cmd_data_i[1];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rtc_alarm_clock.sv
// Two clocks (4 clk/ms 24 h, 1 clk/ms 12 h) share one command bus; each is compared
// every cycle against a time-of-day-in-milliseconds model, plus literal spot checks.
module tb_rtc_alarm_clock;

    logic       clk_i = 1'b0;
    logic       arst_n_i;
    logic       cmd_valid_i;
    logic [2:0] cmd_type_i;
    logic [9:0] cmd_data_i;

    logic [4:0] hours   [2];
    logic [5:0] minutes [2];
    logic [5:0] seconds [2];
    logic [9:0] millis  [2];
    logic       running [2];
    logic       alarm   [2];
    logic       pending [2];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: time of day in ms, cycles into the current ms, and control/alarm state.
    int m_t [2];
    int m_p [2];
    int m_ah[2];
    int m_am[2];
    bit m_run[2];
    bit m_en[2];
    bit m_alarm[2];
    bit m_pend[2];

    logic [2:0] rt;
    logic [9:0] rd;

    always #5 clk_i = ~clk_i;

    rtc_alarm_clock #(.CLKS_PER_MS(4), .HOURS_PER_DAY(24)) dut24 (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .cmd_valid_i(cmd_valid_i),
        .cmd_type_i(cmd_type_i), .cmd_data_i(cmd_data_i),
        .hours_o(hours[0]), .minutes_o(minutes[0]), .seconds_o(seconds[0]),
        .milliseconds_o(millis[0]), .running_o(running[0]), .alarm_o(alarm[0]),
        .alarm_pending_o(pending[0])
    );

    rtc_alarm_clock #(.CLKS_PER_MS(1), .HOURS_PER_DAY(12)) dut12 (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .cmd_valid_i(cmd_valid_i),
        .cmd_type_i(cmd_type_i), .cmd_data_i(cmd_data_i),
        .hours_o(hours[1]), .minutes_o(minutes[1]), .seconds_o(seconds[1]),
        .milliseconds_o(millis[1]), .running_o(running[1]), .alarm_o(alarm[1]),
        .alarm_pending_o(pending[1])
    );

    function automatic int cpm(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int hpd(input int i);
        return (i == 0) ? 24 : 12;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_t[i] = 0;  m_p[i] = 0;  m_ah[i] = 0;  m_am[i] = 0;
            m_run[i] = 1'b1;  m_en[i] = 1'b0;  m_alarm[i] = 1'b0;  m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input bit v, input logic [2:0] t, input logic [9:0] d);
        bit tc, ctrl, tick, fire;
        tc   = v && (t inside {3'd7, 3'd6, 3'd5, 3'd3, 3'd2});
        ctrl = v && (t == 3'd0);
        tick = m_run[i] && !tc && (m_p[i] == cpm(i) - 1);
        if (tc) m_p[i] = 0;
        else if (m_run[i]) m_p[i] = (m_p[i] + 1) % cpm(i);
        fire = 1'b0;
        if (tick) begin
            m_t[i] = (m_t[i] + 1) % (hpd(i) * 3600000);
            fire = m_en[i] && !(ctrl && !d[1]) && (m_t[i] == m_ah[i] * 3600000 + m_am[i] * 60000);
        end
        m_alarm[i] = fire;
        if (fire) m_pend[i] = 1'b1;
        else if (ctrl && d[2]) m_pend[i] = 1'b0;
        if (v) begin
            case (t)
                3'd7: m_t[i] = (int'(d[9:5]) % hpd(i)) * 3600000 + m_t[i] % 3600000;
                3'd6: m_t[i] = (m_t[i] / 3600000) * 3600000 + (int'(d[9:4]) % 60) * 60000 + m_t[i] % 60000;
                3'd5: m_t[i] = (m_t[i] / 60000) * 60000 + (int'(d[9:4]) % 60) * 1000 + m_t[i] % 1000;
                3'd3: m_t[i] = (m_t[i] / 1000) * 1000 + int'(d) % 1000;
                3'd2: m_t[i] = 0;
                3'd4: m_ah[i] = int'(d[9:5]) % hpd(i);
                3'd1: m_am[i] = int'(d[9:4]) % 60;
                default: begin
                    m_run[i] = d[0];
                    m_en[i]  = d[1];
                end
            endcase
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("u%0d hours", i),   32'(hours[i]),   m_t[i] / 3600000);
                check($sformatf("u%0d minutes", i), 32'(minutes[i]), (m_t[i] / 60000) % 60);
                check($sformatf("u%0d seconds", i), 32'(seconds[i]), (m_t[i] / 1000) % 60);
                check($sformatf("u%0d ms", i),      32'(millis[i]),  m_t[i] % 1000);
                check($sformatf("u%0d running", i), 32'(running[i]), 32'(m_run[i]));
                check($sformatf("u%0d alarm", i),   32'(alarm[i]),   32'(m_alarm[i]));
                check($sformatf("u%0d pending", i), 32'(pending[i]), 32'(m_pend[i]));
            end
        end
    end

    // Drives one command (or idle) for one clock; entered after a negedge, returns at the next.
    task automatic cycle(input bit v, input logic [2:0] t, input logic [9:0] d);
        cmd_valid_i = v;
        cmd_type_i  = t;
        cmd_data_i  = d;
        @(posedge clk_i);
        if (arst_n_i) begin
            for (int i = 0; i < 2; i++) model_step(i, v, t, d);
        end
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
    endtask

    task automatic cmd(input logic [2:0] t, input logic [9:0] d);
        cycle(1'b1, t, d);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 3'd0, 10'd0);
    endtask

    function automatic logic [9:0] hdat(input int h);
        return 10'(h << 5);
    endfunction

    function automatic logic [9:0] mdat(input int m);
        return 10'(m << 4);
    endfunction

    task automatic set_time(input int h, input int m, input int s, input int ms);
        cmd(3'd7, hdat(h));
        cmd(3'd6, mdat(m));
        cmd(3'd5, mdat(s));
        cmd(3'd3, 10'(ms));
    endtask

    task automatic expect_time(input int i, input string tag, input int h, input int m,
                               input int s, input int ms);
        check({tag, " h"},  32'(hours[i]),   h);
        check({tag, " m"},  32'(minutes[i]), m);
        check({tag, " s"},  32'(seconds[i]), s);
        check({tag, " ms"}, 32'(millis[i]),  ms);
        check({tag, " model"}, m_t[i], ((h * 60 + m) * 60 + s) * 1000 + ms);
    endtask

    task automatic async_reset();
        #($urandom_range(1, 4));
        arst_n_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        #1 arst_n_i = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        arst_n_i    = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_type_i  = 3'd0;
        cmd_data_i  = 10'd0;
        model_reset();
        repeat (2) @(negedge clk_i);
        for (int i = 0; i < 2; i++) begin
            expect_time(i, $sformatf("u%0d reset", i), 0, 0, 0, 0);
            check($sformatf("u%0d reset running", i), 32'(running[i]), 1);
            check($sformatf("u%0d reset alarm", i),   32'(alarm[i]),   0);
            check($sformatf("u%0d reset pending", i), 32'(pending[i]), 0);
        end
        #1 arst_n_i = 1'b1;
        chk_en = 1'b1;

        // Prescaler: one ms every 4 clocks on the 4 clk/ms unit.
        idle(3);
        expect_time(0, "presc 3clk", 0, 0, 0, 0);
        idle(1);
        expect_time(0, "presc 4clk", 0, 0, 0, 1);
        idle(3996);
        expect_time(0, "presc 4000clk", 0, 0, 1, 0);
        expect_time(1, "u1 4000clk", 0, 0, 4, 0);

        // Full cascade rollover.
        set_time(23, 59, 59, 999);
        expect_time(0, "preroll", 23, 59, 59, 999);
        expect_time(1, "u1 preroll", 11, 59, 59, 999);
        idle(1);
        expect_time(1, "u1 rollover", 0, 0, 0, 0);
        idle(3);
        expect_time(0, "rollover", 0, 0, 0, 0);

        // Set-value modulo with one-cycle readback.
        cmd(3'd7, hdat(30));
        check("mod hours u0", 32'(hours[0]), 6);
        check("mod hours u1", 32'(hours[1]), 6);
        cmd(3'd6, mdat(63));
        check("mod minutes", 32'(minutes[0]), 3);
        cmd(3'd3, 10'd1023);
        check("mod ms", 32'(millis[0]), 23);

        // Pause holds time and prescaler; resume continues from the held phase.
        cmd(3'd2, 10'd0);
        cmd(3'd3, 10'd500);
        cmd(3'd0, 10'b000);
        idle(100);
        expect_time(0, "paused", 0, 0, 0, 500);
        check("paused running", 32'(running[0]), 0);
        cmd(3'd0, 10'b001);
        idle(2);
        expect_time(0, "resume+2", 0, 0, 0, 500);
        idle(1);
        expect_time(0, "resume+3", 0, 0, 0, 501);
        check("resumed running", 32'(running[0]), 1);

        // Alarm 01:00 fires once on the tick into it.
        cmd(3'd4, hdat(1));
        cmd(3'd1, mdat(0));
        cmd(3'd0, 10'b011);
        set_time(0, 59, 59, 999);
        idle(3);
        check("alarm early", 32'(alarm[0]), 0);
        idle(1);
        expect_time(0, "alarm time", 1, 0, 0, 0);
        check("alarm pulse", 32'(alarm[0]), 1);
        check("alarm pending set", 32'(pending[0]), 1);
        idle(1);
        check("alarm pulse width", 32'(alarm[0]), 0);
        check("alarm pending sticky", 32'(pending[0]), 1);
        cmd(3'd0, 10'b111);
        check("alarm pending clear", 32'(pending[0]), 0);

        // Direct set onto the alarm value never fires.
        set_time(1, 0, 0, 0);
        check("direct set alarm", 32'(alarm[0]), 0);
        idle(4);
        check("direct set pending", 32'(pending[0]), 0);

        // Clear coinciding with a fire: set wins.
        set_time(0, 59, 59, 999);
        idle(3);
        cmd(3'd0, 10'b111);
        check("clear vs fire pulse", 32'(alarm[0]), 1);
        check("clear vs fire pending", 32'(pending[0]), 1);
        cmd(3'd0, 10'b111);

        // Disable in the firing cycle suppresses the fire.
        set_time(0, 59, 59, 999);
        idle(3);
        cmd(3'd0, 10'b001);
        expect_time(0, "disable fire time", 1, 0, 0, 0);
        check("disable fire pulse", 32'(alarm[0]), 0);
        check("disable fire pending", 32'(pending[0]), 0);

        // Async reset mid-count; a command held during reset is lost.
        cmd(3'd4, hdat(0));
        cmd(3'd1, mdat(0));
        cmd(3'd0, 10'b011);
        set_time(5, 17, 3, 412);
        idle(2);
        expect_time(0, "pre-reset", 5, 17, 3, 412);
        #2 arst_n_i = 1'b0;
        model_reset();
        cmd_valid_i = 1'b1;
        cmd_type_i  = 3'd7;
        cmd_data_i  = hdat(9);
        #1;
        expect_time(0, "async reset", 0, 0, 0, 0);
        check("async reset running", 32'(running[0]), 1);
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        check("reset holds hours", 32'(hours[0]), 0);
        #1 arst_n_i = 1'b1;
        set_time(23, 59, 59, 999);
        idle(4);
        expect_time(0, "post-reset midnight", 0, 0, 0, 0);
        check("reset disabled alarm", 32'(alarm[0]), 0);
        check("reset disabled pending", 32'(pending[0]), 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 6000; c++) begin
            if (c % 1500 == 1499) begin
                async_reset();
            end else if ($urandom_range(0, 99) < 12) begin
                rt = 3'($urandom_range(0, 7));
                case (rt)
                    3'd7, 3'd4: begin
                        case ($urandom_range(0, 4))
                            0: rd = hdat(0);
                            1: rd = hdat(1);
                            2: rd = hdat(11);
                            3: rd = hdat(23);
                            default: rd = hdat(30);
                        endcase
                        rd[4:0] = 5'($urandom_range(0, 31));
                    end
                    3'd6, 3'd1, 3'd5: begin
                        case ($urandom_range(0, 3))
                            0: rd = mdat(0);
                            1: rd = mdat(1);
                            2: rd = mdat(59);
                            default: rd = mdat(60 + $urandom_range(0, 3));
                        endcase
                        rd[3:0] = 4'($urandom_range(0, 15));
                    end
                    3'd3: rd = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(985, 1023))
                                                           : 10'($urandom_range(0, 1023));
                    3'd0: begin
                        rd = 10'($urandom_range(0, 1023));
                        rd[0] = ($urandom_range(0, 9) != 0);
                        rd[1] = ($urandom_range(0, 3) != 0);
                        rd[2] = ($urandom_range(0, 4) == 0);
                    end
                    default: rd = 10'($urandom_range(0, 1023));
                endcase
                cmd(rt, rd);
            end else begin
                idle(1);
            end
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
